// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared access-type codes and fault bit indices
//
// Purpose: encodings shared by the permission evaluator, the pipeline top
// and anything decoding rsp_fault / fsr_fault.
// Ports: none (package).
package mmu_pkg;

    localparam logic [1:0] TYPE_READ  = 2'b00;
    localparam logic [1:0] TYPE_WRITE = 2'b01;
    localparam logic [1:0] TYPE_FETCH = 2'b10;
    localparam logic [1:0] TYPE_BAD   = 2'b11;

    // Permission triplets are {X,W,R}.
    localparam int PERM_R = 0;
    localparam int PERM_W = 1;
    localparam int PERM_X = 2;

    // Fault vector is {bad_req, priv_rel, no_exec, wr_prot, no_read}.
    // The three denial bits share their index with the permission bit
    // they report on, so a one-hot type select maps straight across.
    localparam int F_NO_READ  = 0;
    localparam int F_WR_PROT  = 1;
    localparam int F_NO_EXEC  = 2;
    localparam int F_PRIV_REL = 3;
    localparam int F_BAD_REQ  = 4;
    localparam int FAULT_W    = 5;

endpackage

// File: rtl/perm_eval.sv
// rtl/perm_eval.sv - combinational access permission evaluator
//
// Purpose: decide allow/fault for one request.
// Ports:
//   typ   in  2  access type (read/write/fetch/illegal)
//   user  in  1  user-mode flag, selects uperm over sperm
//   uperm in  3  user permissions {X,W,R}
//   sperm in  3  supervisor permissions {X,W,R}
//   tt    in  1  transparent translation: always allowed, never faults
//   allow out 1  access permitted
//   fault out 5  {bad_req, priv_rel, no_exec, wr_prot, no_read}
module perm_eval
    import mmu_pkg::*;
(
    input  logic [1:0]         typ,
    input  logic               user,
    input  logic [2:0]         uperm,
    input  logic [2:0]         sperm,
    input  logic               tt,
    output logic               allow,
    output logic [FAULT_W-1:0] fault
);

    logic [2:0] sel;
    logic [2:0] active;
    logic       hit;
    logic       sup_hit;

    always_comb begin
        sel = 3'b000;
        case (typ)
            TYPE_READ:  sel[PERM_R] = 1'b1;
            TYPE_WRITE: sel[PERM_W] = 1'b1;
            TYPE_FETCH: sel[PERM_X] = 1'b1;
            default:    sel = 3'b000;
        endcase

        active  = user ? uperm : sperm;
        hit     = |(active & sel);
        sup_hit = |(sperm & sel);
        allow   = tt | hit;

        fault = '0;
        if (!tt) begin
            if (typ == TYPE_BAD) begin
                fault[F_BAD_REQ] = 1'b1;
            end else if (!hit) begin
                fault[2:0]        = sel;
                // Denied in user mode but the supervisor could have done it.
                fault[F_PRIV_REL] = user & sup_hit;
            end
        end
    end

endmodule

// File: rtl/perm_check_pipe.sv
// rtl/perm_check_pipe.sv - round-robin permission check with fault status
//
// Purpose: arbitrate NPORT requesters, evaluate permissions for the winner,
// hold the result in a single output register, record first fault.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-port request handshake (ready = grant)
//   req_type/user/uperm/sperm/tt/addr  per-port request fields, packed
//   rsp_valid/rsp_ready      result handshake
//   rsp_port/allow/fault     result fields
//   fsr_valid/overflow/fault/port/addr  first-fault record
//   fsr_clear                clears the record
//   fault_cnt                saturating count of faulting results
module perm_check_pipe
    import mmu_pkg::*;
#(
    parameter int NPORT  = 2,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        req_valid,
    output logic [NPORT-1:0]        req_ready,
    input  logic [2*NPORT-1:0]      req_type,
    input  logic [NPORT-1:0]        req_user,
    input  logic [3*NPORT-1:0]      req_uperm,
    input  logic [3*NPORT-1:0]      req_sperm,
    input  logic [NPORT-1:0]        req_tt,
    input  logic [ADDR_W*NPORT-1:0] req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PW-1:0]           rsp_port,
    output logic                    rsp_allow,
    output logic [FAULT_W-1:0]      rsp_fault,
    output logic                    fsr_valid,
    output logic                    fsr_overflow,
    output logic [FAULT_W-1:0]      fsr_fault,
    output logic [PW-1:0]           fsr_port,
    output logic [ADDR_W-1:0]       fsr_addr,
    input  logic                    fsr_clear,
    output logic [CNT_W-1:0]        fault_cnt
);

    logic [PW-1:0]        rr_next;   // first port searched this cycle
    logic [PW-1:0]        gidx;
    logic                 gfound;
    logic                 can_load;
    logic                 grant;
    int                   idx;

    logic [1:0]           sel_type;
    logic                 sel_user;
    logic [2:0]           sel_uperm;
    logic [2:0]           sel_sperm;
    logic                 sel_tt;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 ev_allow;
    logic [FAULT_W-1:0]   ev_fault;
    logic                 fault_load;

    assign can_load = !rsp_valid || rsp_ready;

    // Rotating priority search starting at rr_next.
    always_comb begin
        gfound = 1'b0;
        gidx   = '0;
        idx    = 0;
        for (int k = 0; k < NPORT; k++) begin
            idx = int'(rr_next) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            if (!gfound && req_valid[idx]) begin
                gfound = 1'b1;
                gidx   = PW'(idx);
            end
        end
    end

    assign grant = gfound && can_load && !rst;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gidx] = 1'b1;
    end

    always_comb begin
        sel_type  = '0;
        sel_user  = 1'b0;
        sel_uperm = '0;
        sel_sperm = '0;
        sel_tt    = 1'b0;
        sel_addr  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (gidx == PW'(i)) begin
                sel_type  = req_type[2*i +: 2];
                sel_user  = req_user[i];
                sel_uperm = req_uperm[3*i +: 3];
                sel_sperm = req_sperm[3*i +: 3];
                sel_tt    = req_tt[i];
                sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    perm_eval u_perm_eval (
        .typ   (sel_type),
        .user  (sel_user),
        .uperm (sel_uperm),
        .sperm (sel_sperm),
        .tt    (sel_tt),
        .allow (ev_allow),
        .fault (ev_fault)
    );

    assign fault_load = grant && (ev_fault != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_next      <= '0;
            rsp_valid    <= 1'b0;
            rsp_port     <= '0;
            rsp_allow    <= 1'b0;
            rsp_fault    <= '0;
            fsr_valid    <= 1'b0;
            fsr_overflow <= 1'b0;
            fsr_fault    <= '0;
            fsr_port     <= '0;
            fsr_addr     <= '0;
            fault_cnt    <= '0;
        end else begin
            if (grant) begin
                rsp_valid <= 1'b1;
                rsp_port  <= gidx;
                rsp_allow <= ev_allow;
                rsp_fault <= ev_fault;
                rr_next   <= (gidx == PW'(NPORT - 1)) ? '0 : gidx + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            // A clear in the same cycle as a faulting load makes room for
            // the new record rather than flagging it as lost.
            if (fault_load && (!fsr_valid || fsr_clear)) begin
                fsr_valid    <= 1'b1;
                fsr_overflow <= 1'b0;
                fsr_fault    <= ev_fault;
                fsr_port     <= gidx;
                fsr_addr     <= sel_addr;
            end else if (fault_load) begin
                fsr_overflow <= 1'b1;
            end else if (fsr_clear) begin
                fsr_valid    <= 1'b0;
                fsr_overflow <= 1'b0;
            end

            if (fault_load && (fault_cnt != '1)) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/perm_check_pipe.md
PERM_CHECK_PIPE -- requirements
Module: perm_check_pipe

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of requesting ports, 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: logical address width.
REQ-003 SHALL have parameter CNT_W, default 16: fault counter width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NPORT  per-port request valid.
REQ-007 SHALL have port req_ready  out  NPORT  per-port request accepted (grant).
REQ-008 SHALL have port req_type  in  2*NPORT  per-port access type: 00 read, 01 write, 10 fetch, 11 illegal.
REQ-009 SHALL have port req_user  in  NPORT  per-port user-mode flag.
REQ-010 SHALL have port req_uperm  in  3*NPORT  per-port user permissions {X,W,R}.
REQ-011 SHALL have port req_sperm  in  3*NPORT  per-port supervisor permissions {X,W,R}.
REQ-012 SHALL have port req_tt  in  NPORT  per-port transparent-translation bypass.
REQ-013 SHALL have port req_addr  in  ADDR_W*NPORT  per-port address (diagnostics only).
REQ-014 SHALL have port rsp_valid  out  1  result valid.
REQ-015 SHALL have port rsp_ready  in  1  result consumed.
REQ-016 SHALL have port rsp_port  out  clog2(NPORT), min 1  originating port.
REQ-017 SHALL have port rsp_allow  out  1  access permitted.
REQ-018 SHALL have port rsp_fault  out  5  {bad_req, priv_rel, no_exec, wr_prot, no_read}.
REQ-019 SHALL have port fsr_valid, fsr_overflow  out  1 each  first-fault captured / later fault lost.
REQ-020 SHALL have port fsr_fault, fsr_port, fsr_addr  out  5 / port width / ADDR_W  captured first-fault record.
REQ-021 SHALL have port fsr_clear  in  1  clears fault status.
REQ-022 SHALL have port fault_cnt  out  CNT_W  saturating count of faulting results.

Function
REQ-023 SHALL evaluate per request: active perm = user ? uperm : sperm; allow = tt | (type!=11 & active bit for type set).
REQ-024 SHALL set fault bits only when tt=0: no_read/wr_prot/no_exec when the type's active bit is clear; priv_rel when user, denied, and sperm bit for type set; bad_req when type=11; all zero when tt=1.
REQ-025 SHALL hold one result in an output register; rsp_* valid one cycle after grant (latency 1).
REQ-026 SHALL grant at most one port per cycle, and only when output register empty or rsp_ready=1 that cycle.
REQ-027 SHALL arbitrate round-robin: search starts at port after last granted; pointer advances only on grant.
REQ-028 SHALL keep rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-029 SHALL on simultaneous rsp_ready and grant, replace result with no bubble (full throughput).
REQ-030 SHALL capture fault record (fault, port, addr) when a result with nonzero fault is loaded and fsr_valid=0; set fsr_valid.
REQ-031 SHALL set fsr_overflow when a faulting result loads while fsr_valid=1; record unchanged.
REQ-032 SHALL on fsr_clear coincident with faulting load: capture new record, fsr_overflow=0.
REQ-033 SHALL increment fault_cnt per faulting load, saturating at all-ones; fsr_clear does not affect fault_cnt.

Reset
REQ-034 SHALL on rst clear rsp_valid, rsp_allow, rsp_fault, rsp_port, fsr_*, fault_cnt to 0; req_ready=0; RR pointer to port 0.
REQ-035 SHALL discard any held result when rst asserts mid-transfer; no grant during rst.

Structure
REQ-036 SHALL place access-type codes and fault bit indices in shared package mmu_pkg.
REQ-037 SHALL instantiate a combinational sub-module perm_eval (REQ-023/024) once, after the arbiter mux.

Verification
REQ-038 SHALL test: port0 read, user, uperm=001 -> next cycle rsp_allow=1, fault=00000, rsp_port=0.
REQ-039 SHALL test: user write, uperm=001, sperm=011 -> allow=0, fault=01010; fsr_valid=1, fault_cnt=1.
REQ-040 SHALL test: both ports valid 4 cycles, rsp_ready=1 -> grants 0,1,0,1, one result per cycle.
REQ-041 SHALL test: rsp_ready=0 with result held -> req_ready=0, rsp_* stable; release -> drain then next grant.
REQ-042 SHALL test: type=11, tt=1 -> allow=1, fault=0; type=11, tt=0 -> fault=10000; second fault -> fsr_overflow=1.
REQ-043 SHALL test: CNT_W=2, five faults -> fault_cnt=3; rst mid-hold -> rsp_valid=0 next cycle.
